arbitro_leds_som: RTL and testbench
===================================

# arbitro_leds_som

Shared-output scheduler for the game's LED bank and buzzer. Three requesters compete for the outputs: memory playback, player-echo feedback and the end-of-game indication. The block grants them one at a time by fixed priority and shows the latched LED pattern with a per-LED tone for a fixed hold time, followed by a silent gap. It then returns a one-cycle done pulse to the served requester, so control units only raise a request and wait for done instead of timing the display themselves.

## Interface
Parameters:
- HOLD_CYCLES, 500: cycles the pattern and tone stay on (≥1).
- GAP_CYCLES, 100: silent cycles after hold, before done (0 allowed = no gap).
- TONE_HALF_BASE, 1: base half-period of the buzzer square wave, in cycles (≥1).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clock clock.
- req  in  3  request per requester; bit 0 memory playback, bit 1 player echo, bit 2 end-of-game.
- code0, code1, code2  in  4 each  LED pattern of each requester (one-hot expected).
- cancela  in  1  synchronous abort of the current service.
- grant  out  3  one-hot owner of the outputs; 0 when idle.
- done  out  3  one-cycle completion pulse to the owner.
- leds  out  4  driven LED pattern.
- buzzer  out  1  square-wave tone.
- busy  out  1  high in any state but IDLE.
- db_estado  out  3  current state code.

## Operation
- States and codes: IDLE=0, HOLD=1, GAP=2, DONE=3.
- IDLE: on a rising edge with any req bit high:
  - The winner is chosen by fixed priority, 2 > 1 > 0.
  - The winner's code is latched into code_reg and its index into owner.
  - The state goes to HOLD, and the hold counter and tone counter clear.
  - With no request, the state stays IDLE.
- HOLD:
  - leds = code_reg and grant = onehot(owner).
  - The counter runs 0..HOLD_CYCLES-1. At the last count the state goes to GAP, or to DONE if GAP_CYCLES=0.
- GAP: leds=0, buzzer=0 and grant held. The counter runs 0..GAP_CYCLES-1, then the state goes to DONE.
- DONE: done[owner]=1 for exactly this cycle, grant held, leds=0, buzzer=0. The state then goes to IDLE.
- Tone:
  - k = index of the lowest set bit of code_reg.
  - Half-period H = TONE_HALF_BASE*(k+1).
  - buzzer is 1 in the first HOLD cycle and toggles every H cycles while in HOLD.
  - If code_reg = 0, leds = 0 and buzzer = 0, but all timing is unchanged.
- No preemption. A higher-priority request arriving during service waits for IDLE.
- Requests are sampled only in IDLE. Dropping req after grant does not abort service; done still fires.
- A requester still holding req after its done pulse counts as a new request at the next IDLE evaluation.
- cancela is checked in every state and takes priority over all other transitions.
  - Next state is IDLE, with no done pulse.
  - grant, leds and buzzer are 0 from the next cycle.
  - cancela in IDLE blocks a grant on that edge.
- Counters are sized by $clog2 of their parameter plus 1. They never wrap during a service.

## Timing
- Reset values: state IDLE, grant=0, done=0, leds=0, buzzer=0, busy=0, db_estado=0. Internal counters and registers are 0.
- Reset asserted mid-service forces the reset values immediately, with no done pulse.
- With req sampled high at edge t:
  - grant, busy and leds are valid in cycle t+1.
  - leds are on for exactly HOLD_CYCLES cycles.
  - done pulses in cycle t+1+HOLD_CYCLES+GAP_CYCLES.
- Back-to-back service of a continuously requesting source has period HOLD_CYCLES+GAP_CYCLES+2 cycles, with the IDLE cycle included.
- All outputs are registered or decoded from state and registers only (Moore). There is no combinational path from req or code to the outputs.

## Test plan
- **Single request.** HOLD=4, GAP=2, BASE=1. Pulse req=001 with code0=0010 at edge 0:
  - grant=001 and leds=0010 in cycles 1–4.
  - leds=0 in cycles 5–6.
  - done=001 in cycle 7, then IDLE in cycle 8.
- **Priority.** req=111 sampled together → owner 2 served first. Holding req at 011 after that → owner 1, then owner 0. grant is never multi-hot.
- **Tone.** HOLD=8, code=0100 (k=2, H=3) → buzzer reads 1,1,1,0,0,0,1,1 over the HOLD cycles. code=0000 → buzzer 0 and leds 0 while timing is intact.
- **No preemption.** Raise req[2] during HOLD of owner 0 → owner 0 completes with its done. Owner 2 is granted one IDLE cycle later.
- **Abort.** cancela in HOLD cycle 2 → IDLE next cycle, outputs 0, no done. With cancela and req both high in IDLE → no grant.
- **Edge cases.**
  - GAP_CYCLES=0: done arrives right after the last HOLD cycle.
  - Async reset mid-HOLD: all outputs 0 at once; normal operation after release.

Source files
------------

// File: rtl/arbitro_leds_som.sv
// Shared LED/buzzer scheduler: grants one of three requesters by fixed priority,
// shows its pattern with a per-LED tone for HOLD_CYCLES, stays silent for GAP_CYCLES, then pulses done.
module arbitro_leds_som #(
  parameter int HOLD_CYCLES    = 500,
  parameter int GAP_CYCLES     = 100,
  parameter int TONE_HALF_BASE = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] req,
  input  logic [3:0] code0,
  input  logic [3:0] code1,
  input  logic [3:0] code2,
  input  logic       cancela,
  output logic [2:0] grant,
  output logic [2:0] done,
  output logic [3:0] leds,
  output logic       buzzer,
  output logic       busy,
  output logic [2:0] db_estado
);
  localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW      = $clog2(CNT_MAX) + 1;
  localparam int TW      = $clog2(4 * TONE_HALF_BASE) + 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HOLD = 3'd1,
    GAP  = 3'd2,
    DONE = 3'd3
  } estado_t;

  estado_t       estado;
  logic [1:0]    owner;
  logic [3:0]    code_reg;
  logic [CW-1:0] cnt;
  logic [TW-1:0] tone_cnt;
  logic [TW-1:0] half;
  logic [1:0]    win;
  logic [3:0]    win_code;

  function automatic logic [2:0] onehot(input logic [1:0] idx);
    return 3'b001 << idx;
  endfunction

  // Fixed priority 2 > 1 > 0
  always_comb begin
    win      = 2'd0;
    win_code = code0;
    if (req[2]) begin
      win      = 2'd2;
      win_code = code2;
    end else if (req[1]) begin
      win      = 2'd1;
      win_code = code1;
    end
  end

  // Tone half-period follows the lowest lit LED; irrelevant when the pattern is empty
  always_comb begin
    half = TW'(TONE_HALF_BASE);
    if (code_reg[0])      half = TW'(TONE_HALF_BASE);
    else if (code_reg[1]) half = TW'(2 * TONE_HALF_BASE);
    else if (code_reg[2]) half = TW'(3 * TONE_HALF_BASE);
    else if (code_reg[3]) half = TW'(4 * TONE_HALF_BASE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado   <= IDLE;
      owner    <= '0;
      code_reg <= '0;
      cnt      <= '0;
      tone_cnt <= '0;
      grant    <= '0;
      done     <= '0;
      leds     <= '0;
      buzzer   <= 1'b0;
    end else begin
      done <= '0;
      if (cancela) begin
        estado   <= IDLE;
        cnt      <= '0;
        tone_cnt <= '0;
        grant    <= '0;
        leds     <= '0;
        buzzer   <= 1'b0;
      end else begin
        case (estado)
          IDLE: begin
            if (|req) begin
              estado   <= HOLD;
              owner    <= win;
              code_reg <= win_code;
              grant    <= onehot(win);
              leds     <= win_code;
              buzzer   <= |win_code;
              cnt      <= '0;
              tone_cnt <= '0;
            end
          end
          HOLD: begin
            if (cnt == HOLD_LAST) begin
              cnt    <= '0;
              leds   <= '0;
              buzzer <= 1'b0;
              if (GAP_CYCLES == 0) begin
                estado <= DONE;
                done   <= onehot(owner);
              end else begin
                estado <= GAP;
              end
            end else begin
              cnt <= cnt + CW'(1);
              if (tone_cnt == half - TW'(1)) begin
                tone_cnt <= '0;
                buzzer   <= ~buzzer & (|code_reg);
              end else begin
                tone_cnt <= tone_cnt + TW'(1);
              end
            end
          end
          GAP: begin
            if (cnt == GAP_LAST) begin
              cnt    <= '0;
              estado <= DONE;
              done   <= onehot(owner);
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          DONE: begin
            estado <= IDLE;
            grant  <= '0;
          end
          default: estado <= IDLE;
        endcase
      end
    end
  end

  assign busy      = (estado != IDLE);
  assign db_estado = estado;
endmodule

// File: tb/tb_arbitro_leds_som.sv
// Scoreboard bench: each request pushes its expected service; the monitor pops and checks at done/abort.
module tb_arbitro_leds_som;
  localparam int HA = 4, GA = 2, HB = 8, GB = 0, BASE = 1;

  logic       clock = 1'b0, reset = 1'b1;
  logic [2:0] req_a = '0, req_b = '0;
  logic [3:0] c0a = '0, c1a = '0, c2a = '0, c0b = '0, zero4 = '0;
  logic       can_a = 1'b0, can_b = 1'b0;
  logic [2:0] grant_a, done_a, est_a, grant_b, done_b, est_b;
  logic [3:0] leds_a, leds_b;
  logic       buzzer_a, busy_a, buzzer_b, busy_b;

  arbitro_leds_som #(.HOLD_CYCLES(HA), .GAP_CYCLES(GA), .TONE_HALF_BASE(BASE)) u_a (
    .clock(clock), .reset(reset), .req(req_a), .code0(c0a), .code1(c1a), .code2(c2a),
    .cancela(can_a), .grant(grant_a), .done(done_a), .leds(leds_a), .buzzer(buzzer_a),
    .busy(busy_a), .db_estado(est_a));

  arbitro_leds_som #(.HOLD_CYCLES(HB), .GAP_CYCLES(GB), .TONE_HALF_BASE(BASE)) u_b (
    .clock(clock), .reset(reset), .req(req_b), .code0(c0b), .code1(zero4), .code2(zero4),
    .cancela(can_b), .grant(grant_b), .done(done_b), .leds(leds_b), .buzzer(buzzer_b),
    .busy(busy_b), .db_estado(est_b));

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Expected buzzer over the HOLD window, straight from the tone definition
  function automatic logic [15:0] exp_tr(input logic [3:0] c, input int n);
    logic [15:0] t;
    int k;
    t = '0;
    k = 0;
    if (c != 4'd0) begin
      while (!c[k]) k++;
      for (int i = 0; i < n; i++) t[i] = (((i / (BASE * (k + 1))) % 2) == 0);
    end
    return t;
  endfunction

  typedef struct {
    logic [2:0] g;
    logic [3:0] code;
    int         start;
    int         len;
    bit         abort;
  } exp_t;

  exp_t sb[$];
  int   q_b[$];

  function automatic void push(input logic [2:0] g, input logic [3:0] code, input int start,
                               input int len, input bit abort);
    exp_t e;
    e.g = g; e.code = code; e.start = start; e.len = len; e.abort = abort;
    sb.push_back(e);
  endfunction

  // Monitor for DUT a
  bit          in_svc = 1'b0;
  exp_t        cur;
  int          s0, idx, sbad;
  logic [15:0] btr;
  always @(negedge clock) begin
    if (!in_svc && done_a != 3'b0) chk("stray_done", done_a, 3'b0);
    if (!in_svc && grant_a != 3'b0) begin
      if (sb.size() == 0) chk("unexp_grant", grant_a, 3'b0);
      else begin
        in_svc = 1'b1; cur = sb[0]; s0 = cyc; idx = 0; sbad = 0; btr = '0;
      end
    end
    if (in_svc) begin
      if (done_a != 3'b0 || grant_a == 3'b0) begin
        void'(sb.pop_front());
        chk("end_kind", {31'b0, |done_a}, {31'b0, !cur.abort});
        if (cur.len >= 0) chk("svc_len", cyc - s0, cur.len);
        if (cur.start >= 0) chk("svc_start", s0, cur.start);
        if (done_a != 3'b0) begin
          chk("done_own", done_a, cur.g);
          chk("grant_at_done", grant_a, cur.g);
          chk("svc_samples", sbad, 0);
          chk("tone", btr, exp_tr(cur.code, HA));
        end
        in_svc = 1'b0;
      end else begin
        if ($countones(grant_a) != 1 || grant_a != cur.g || busy_a != 1'b1) sbad++;
        if (idx < HA) begin
          if (leds_a != cur.code) sbad++;
          btr[idx] = buzzer_a;
        end else if (leds_a != 4'b0 || buzzer_a != 1'b0) sbad++;
        idx++;
      end
    end
  end

  // Monitor for DUT b: done cycle only
  always @(negedge clock) begin
    if (done_b != 3'b0) begin
      if (q_b.size() == 0) chk("b_stray_done", done_b, 3'b0);
      else begin
        chk("b_done_cycle", cyc, q_b.pop_front());
        chk("b_done_own", done_b, 3'b001);
      end
    end
  end

  task automatic step();
    @(posedge clock); #2;
  endtask

  task automatic wait_grant_a(input logic [2:0] g);
    int n = 0;
    while (grant_a !== g && n < 200) begin @(negedge clock); n++; end
    if (n >= 200) chk("timeout_grant", grant_a, g);
    step();
  endtask

  task automatic wait_idle_a();
    int n = 0;
    while ((busy_a || sb.size() != 0 || in_svc) && n < 300) begin @(negedge clock); n++; end
    if (n >= 300) chk("timeout_idle", {31'b0, busy_a}, 0);
    step();
  endtask

  task automatic chk_zero_a(input string tag);
    chk({tag, "_grant"}, grant_a, 0);
    chk({tag, "_done"}, done_a, 0);
    chk({tag, "_leds"}, leds_a, 0);
    chk({tag, "_buzzer"}, buzzer_a, 0);
    chk({tag, "_busy"}, busy_a, 0);
    chk({tag, "_estado"}, est_a, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int bb;
    logic [15:0] tb_tr;
    step();
    chk_zero_a("rst");
    chk("rst_b_busy", busy_b, 0);
    step();
    reset = 1'b0;
    step();

    // single request, code 0010
    c0a = 4'b0010; req_a = 3'b001;
    push(3'b001, 4'b0010, cyc + 1, HA + GA, 0);
    step(); req_a = '0;
    wait_idle_a();

    // tone on requester 1, code 0100
    c1a = 4'b0100; req_a = 3'b010;
    push(3'b010, 4'b0100, cyc + 1, HA + GA, 0);
    step(); req_a = '0;
    wait_idle_a();

    // empty pattern keeps timing, no light or sound
    c0a = 4'b0000; req_a = 3'b001;
    push(3'b001, 4'b0000, cyc + 1, HA + GA, 0);
    step(); req_a = '0;
    wait_idle_a();

    // priority: 111 then 011 then 001
    c0a = 4'b0001; c1a = 4'b0010; c2a = 4'b1000; req_a = 3'b111;
    push(3'b100, 4'b1000, cyc + 1, HA + GA, 0);
    push(3'b010, 4'b0010, cyc + 1 + (HA + GA + 2), HA + GA, 0);
    push(3'b001, 4'b0001, cyc + 1 + 2 * (HA + GA + 2), HA + GA, 0);
    wait_grant_a(3'b100); req_a = 3'b011;
    wait_grant_a(3'b010); req_a = 3'b001;
    wait_grant_a(3'b001); req_a = 3'b000;
    wait_idle_a();

    // no preemption: requester 2 raised during owner 0's HOLD
    c0a = 4'b0100; req_a = 3'b001;
    push(3'b001, 4'b0100, cyc + 1, HA + GA, 0);
    push(3'b100, 4'b1000, cyc + 1 + (HA + GA + 2), HA + GA, 0);
    wait_grant_a(3'b001); req_a = 3'b100;
    wait_grant_a(3'b100); req_a = 3'b000;
    wait_idle_a();

    // cancel in the second HOLD cycle
    c0a = 4'b0001; req_a = 3'b001;
    push(3'b001, 4'b0001, cyc + 1, 2, 1);
    step(); req_a = '0;
    step(); can_a = 1'b1;
    step(); can_a = 1'b0;
    #1 chk_zero_a("abort");
    wait_idle_a();

    // cancel together with a request in IDLE blocks the grant
    req_a = 3'b001; can_a = 1'b1;
    step(); req_a = '0; can_a = 1'b0;
    #1 chk("cancel_idle_grant", grant_a, 0);
    chk("cancel_idle_busy", busy_a, 0);
    step(); step();
    chk("cancel_idle_sb", sb.size(), 0);

    // async reset mid-HOLD
    c0a = 4'b0010; req_a = 3'b001;
    push(3'b001, 4'b0010, cyc + 1, -1, 1);
    wait_grant_a(3'b001); req_a = '0;
    reset = 1'b1;
    #1 chk_zero_a("areset");
    step(); step();
    reset = 1'b0;
    step();
    c0a = 4'b1000; req_a = 3'b001;
    push(3'b001, 4'b1000, cyc + 1, HA + GA, 0);
    step(); req_a = '0;
    wait_idle_a();

    // DUT b: HOLD=8, no gap, tone for code 0100
    c0b = 4'b0100; req_b = 3'b001;
    q_b.push_back(cyc + 1 + HB + GB);
    step(); req_b = '0;
    bb = 0; tb_tr = '0;
    for (int i = 0; i < HB; i++) begin
      @(negedge clock);
      if (leds_b != 4'b0100 || grant_b != 3'b001) bb++;
      tb_tr[i] = buzzer_b;
    end
    chk("b_hold_leds", bb, 0);
    chk("b_tone", tb_tr, exp_tr(4'b0100, HB));
    @(negedge clock);
    chk("b_leds_at_done", leds_b, 0);
    @(negedge clock);
    chk("b_idle_after_done", busy_b, 0);
    chk("b_queue_empty", q_b.size(), 0);
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
